// File: rtl/vga_sprite_overlay_if.sv
// Video stream bundle for the sprite overlay.
// Inputs come from the palette lookup and sync generator.
// Outputs go to the VGA DAC pins.
// There is no flow control: every signal is valid on every pixel clock.
interface vga_sprite_overlay_if;
  logic        iBLANK_n;
  logic        iHS;
  logic        iVS;
  logic [23:0] bgr_in;
  logic        oBLANK_n;
  logic        oHS;
  logic        oVS;
  logic [23:0] bgr_out;

  // Upstream side: the source that drives the raw video stream.
  modport master (
    output iBLANK_n, iHS, iVS, bgr_in,
    input  oBLANK_n, oHS, oVS, bgr_out
  );

  // Overlay side: takes in the raw stream and returns the composited stream.
  modport slave (
    input  iBLANK_n, iHS, iVS, bgr_in,
    output oBLANK_n, oHS, oVS, bgr_out
  );
endinterface

// File: rtl/vga_sprite_overlay.sv
// Keyboard-driven solid-colour sprite overlay for the VGA pipeline.
// Key commands are held pending and applied once per frame, on the
// vertical sync fall, so the sprite never tears.
//
// Key strobe protocol: ps2_key_pressed is an asynchronous level strobe.
// Its rising edge, once synchronised, marks one byte on ps2_out. ps2_out
// is stable while the strobe is high and for at least 3 clocks after its
// rising edge. There is no ready signal: a new byte overwrites the pending
// command.
module vga_sprite_overlay #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          SPR_W     = 30,
  parameter int          SPR_H     = 30,
  parameter int          STEP      = 15,
  parameter int          INIT_X    = 340,
  parameter int          INIT_Y    = 200,
  parameter logic [23:0] SPR_COLOR = 24'hFF0000
) (
  input  logic                 iVGA_CLK,
  input  logic                 iRST_n,
  vga_sprite_overlay_if.slave  vid,
  input  logic                 ps2_key_pressed,
  input  logic [7:0]           ps2_out,
  output logic [15:0]          pos_x,
  output logic [15:0]          pos_y,
  output logic                 sprite_on,
  output logic                 dbg_brk_o
);
  localparam logic [15:0] X_LAST  = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST  = 16'(V_ACTIVE - 1);
  localparam logic [16:0] X_MAX   = 17'(H_ACTIVE - SPR_W);
  localparam logic [16:0] Y_MAX   = 17'(V_ACTIVE - SPR_H);
  localparam logic [16:0] SPR_W17 = 17'(SPR_W);
  localparam logic [16:0] SPR_H17 = 17'(SPR_H);
  localparam logic [16:0] STEP17  = 17'(STEP);
  localparam logic [15:0] STEP16  = 16'(STEP);

  typedef enum logic [2:0] {
    CMD_NONE, CMD_LEFT, CMD_RIGHT, CMD_UP, CMD_DOWN, CMD_TOGGLE, CMD_CENTER
  } cmd_e;

  typedef enum logic {KEY_IDLE, KEY_BRK} key_state_e;

  logic [15:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [15:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic        on_q, on_d;
  cmd_e        cmd_q, cmd_d, code_cmd;
  key_state_e  key_state_q, key_state_d;
  logic [1:0]  sync_q;
  logic        prev_q;
  logic        blank_q, hs_q, vs_q;
  logic [23:0] bgr_q;
  logic        key_edge, key_accept, commit, in_spr;
  logic [16:0] x17, y17, px17, py17, sum_x, sum_y;

  assign key_edge = sync_q[1] & ~prev_q;
  assign commit   = vs_q & ~vid.iVS;

  assign x17   = {1'b0, x_cnt_q};
  assign y17   = {1'b0, y_cnt_q};
  assign px17  = {1'b0, pos_x_q};
  assign py17  = {1'b0, pos_y_q};
  assign sum_x = px17 + STEP17;
  assign sum_y = py17 + STEP17;

  assign in_spr = on_q && (x17 >= px17) && (x17 < px17 + SPR_W17)
                       && (y17 >= py17) && (y17 < py17 + SPR_H17);

  // Synchronise the key strobe and remember its last value for edge detection.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ps2_key_pressed};
      prev_q <= sync_q[1];
    end
  end

  // Key FSM state register.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) key_state_q <= KEY_IDLE;
    else         key_state_q <= key_state_d;
  end

  // Key FSM next state: an F0 arms break mode, which swallows the next byte.
  always_comb begin
    key_state_d = key_state_q;
    if (key_edge) begin
      case (key_state_q)
        KEY_IDLE: if (ps2_out == 8'hF0) key_state_d = KEY_BRK;
        KEY_BRK:  key_state_d = KEY_IDLE;
        default:  key_state_d = KEY_IDLE;
      endcase
    end
  end

  // Key FSM outputs: accept a make code only outside break mode.
  always_comb begin
    key_accept = key_edge && (key_state_q == KEY_IDLE) && (ps2_out != 8'hF0);
    dbg_brk_o  = (key_state_q == KEY_BRK);
  end

  // Map scan codes to commands; unknown codes map to NONE and are dropped.
  always_comb begin
    case (ps2_out)
      8'h1C:   code_cmd = CMD_LEFT;
      8'h23:   code_cmd = CMD_RIGHT;
      8'h1D:   code_cmd = CMD_UP;
      8'h1B:   code_cmd = CMD_DOWN;
      8'h29:   code_cmd = CMD_TOGGLE;
      8'h2D:   code_cmd = CMD_CENTER;
      default: code_cmd = CMD_NONE;
    endcase
  end

  // Pending command: a fresh key wins over the commit clear.
  // A key landing on the commit cycle therefore waits for the next frame.
  always_comb begin
    cmd_d = cmd_q;
    if (commit) cmd_d = CMD_NONE;
    if (key_accept && (code_cmd != CMD_NONE)) cmd_d = code_cmd;
  end

  // Apply the pending command at the frame boundary, clamped to the screen.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    on_d    = on_q;
    if (commit) begin
      case (cmd_q)
        CMD_LEFT:   pos_x_d = (pos_x_q < STEP16) ? 16'd0 : pos_x_q - STEP16;
        CMD_RIGHT:  pos_x_d = (sum_x > X_MAX) ? X_MAX[15:0] : sum_x[15:0];
        CMD_UP:     pos_y_d = (pos_y_q < STEP16) ? 16'd0 : pos_y_q - STEP16;
        CMD_DOWN:   pos_y_d = (sum_y > Y_MAX) ? Y_MAX[15:0] : sum_y[15:0];
        CMD_TOGGLE: on_d    = ~on_q;
        CMD_CENTER: begin
          pos_x_d = 16'(INIT_X);
          pos_y_d = 16'(INIT_Y);
        end
        default: ;
      endcase
    end
  end

  // Pixel counters: clear on frame start, count active pixels, y saturates.
  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (!vid.iHS && !vid.iVS) begin
      x_cnt_d = 16'd0;
      y_cnt_d = 16'd0;
    end else if (vid.iBLANK_n) begin
      if (x_cnt_q == X_LAST) begin
        x_cnt_d = 16'd0;
        if (y_cnt_q != Y_LAST) y_cnt_d = y_cnt_q + 16'd1;
      end else begin
        x_cnt_d = x_cnt_q + 16'd1;
      end
    end
  end

  // Control state: counters, pending command, committed position.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      x_cnt_q <= 16'd0;
      y_cnt_q <= 16'd0;
      cmd_q   <= CMD_NONE;
      pos_x_q <= 16'(INIT_X);
      pos_y_q <= 16'(INIT_Y);
      on_q    <= 1'b1;
    end else begin
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      cmd_q   <= cmd_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      on_q    <= on_d;
    end
  end

  // One-cycle output stage that keeps syncs and composited pixel aligned.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      bgr_q   <= 24'd0;
    end else begin
      blank_q <= vid.iBLANK_n;
      hs_q    <= vid.iHS;
      vs_q    <= vid.iVS;
      bgr_q   <= !vid.iBLANK_n ? 24'd0 : (in_spr ? SPR_COLOR : vid.bgr_in);
    end
  end

  assign vid.oBLANK_n = blank_q;
  assign vid.oHS      = hs_q;
  assign vid.oVS      = vs_q;
  assign vid.bgr_out  = bgr_q;
  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;
  assign sprite_on    = on_q;
endmodule

// File: tb/tb_vga_sprite_overlay.sv
// Directed bench for vga_sprite_overlay on a reduced 64x48 screen.
module tb_vga_sprite_overlay;
  localparam int          H    = 64;
  localparam int          V    = 48;
  localparam int          SW   = 8;
  localparam int          SH   = 6;
  localparam int          STEP = 5;
  localparam int          IX   = 34;
  localparam int          IY   = 20;
  localparam logic [23:0] COL  = 24'hFF0000;
  localparam logic [23:0] BG   = 24'h000055;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strobe = 1'b0;
  logic [7:0]  code = 8'h00;
  logic [15:0] pos_x, pos_y;
  logic        sprite_on, dbg_brk;

  int n_cmp = 0;
  int n_err = 0;
  int m_x = IX;
  int m_y = IY;
  logic m_on = 1'b1;
  logic [26:0] exp_pix;
  logic exp_vld = 1'b0;
  int spr_seen;

  vga_sprite_overlay_if vid();

  vga_sprite_overlay #(
    .H_ACTIVE(H), .V_ACTIVE(V), .SPR_W(SW), .SPR_H(SH), .STEP(STEP),
    .INIT_X(IX), .INIT_Y(IY), .SPR_COLOR(COL)
  ) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .vid(vid),
    .ps2_key_pressed(strobe), .ps2_out(code),
    .pos_x(pos_x), .pos_y(pos_y), .sprite_on(sprite_on), .dbg_brk_o(dbg_brk)
  );

  always #5 clk = ~clk;

  // Drive one pixel at the falling edge and check the previous one.
  task automatic drive_pix(input logic blank, input logic hs, input logic vs,
                           input logic [23:0] col);
    @(negedge clk);
    if (exp_vld) begin
      n_cmp++;
      if ({vid.oBLANK_n, vid.oHS, vid.oVS, vid.bgr_out} !== exp_pix) begin
        n_err++;
        $display("FAIL pixel: got %h want %h", {vid.oBLANK_n, vid.oHS, vid.oVS, vid.bgr_out}, exp_pix);
      end
      if (vid.bgr_out === COL) spr_seen++;
    end
    vid.iBLANK_n = blank;
    vid.iHS      = hs;
    vid.iVS      = vs;
    vid.bgr_in   = BG;
    exp_pix      = {blank, hs, vs, blank ? col : 24'h0};
    exp_vld      = 1'b1;
  endtask

  task automatic send_key(input logic [7:0] c);
    @(negedge clk);
    code   = c;
    strobe = 1'b1;
    repeat (4) @(negedge clk);
    strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic commit_frame();
    @(negedge clk);
    vid.iVS = 1'b0;
    @(negedge clk);
    vid.iVS = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    vid.iBLANK_n = 1'b0; vid.iHS = 1'b1; vid.iVS = 1'b1; vid.bgr_in = BG;
    #12;
    n_cmp++; if (pos_x !== 16'(IX)) begin n_err++; $display("FAIL reset_pos_x: got %0d want %0d", pos_x, IX); end
    n_cmp++; if (pos_y !== 16'(IY)) begin n_err++; $display("FAIL reset_pos_y: got %0d want %0d", pos_y, IY); end
    n_cmp++; if (sprite_on !== 1'b1) begin n_err++; $display("FAIL reset_sprite_on: got %b want 1", sprite_on); end
    n_cmp++; if (dbg_brk !== 1'b0) begin n_err++; $display("FAIL reset_brk: got %b want 0", dbg_brk); end
    n_cmp++;
    if ({vid.oBLANK_n, vid.oHS, vid.oVS, vid.bgr_out} !== {3'b011, 24'h0}) begin
      n_err++; $display("FAIL reset_video: got %h want %h", {vid.oBLANK_n, vid.oHS, vid.oVS, vid.bgr_out}, {3'b011, 24'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full frame with a hand-built sync pattern; every output pixel is checked.
  task automatic test_frame();
    int want;
    logic hit;
    spr_seen = 0;
    want = m_on ? SW * SH : 0;
    drive_pix(1'b0, 1'b0, 1'b0, 24'h0);
    drive_pix(1'b0, 1'b0, 1'b0, 24'h0);
    drive_pix(1'b0, 1'b1, 1'b1, 24'h0);
    drive_pix(1'b0, 1'b1, 1'b1, 24'h0);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        hit = m_on && (x >= m_x) && (x < m_x + SW) && (y >= m_y) && (y < m_y + SH);
        drive_pix(1'b1, 1'b1, 1'b1, hit ? COL : BG);
      end
      for (int h = 0; h < 4; h++) drive_pix(1'b0, (h == 1 || h == 2) ? 1'b0 : 1'b1, 1'b1, 24'h0);
    end
    drive_pix(1'b0, 1'b1, 1'b1, 24'h0);
    drive_pix(1'b0, 1'b1, 1'b1, 24'h0);
    exp_vld = 1'b0;
    n_cmp++;
    if (spr_seen != want) begin n_err++; $display("FAIL frame_sprite_count: got %0d want %0d", spr_seen, want); end
  endtask

  task automatic test_move_right();
    send_key(8'h23);
    n_cmp++; if (pos_x !== 16'(IX)) begin n_err++; $display("FAIL right_pending: got %0d want %0d", pos_x, IX); end
    commit_frame();
    m_x = 39;
    n_cmp++; if (pos_x !== 16'(m_x)) begin n_err++; $display("FAIL right_commit: got %0d want %0d", pos_x, m_x); end
    n_cmp++; if (pos_y !== 16'(IY)) begin n_err++; $display("FAIL right_y_held: got %0d want %0d", pos_y, IY); end
    commit_frame();
    n_cmp++; if (pos_x !== 16'(m_x)) begin n_err++; $display("FAIL right_once: got %0d want %0d", pos_x, m_x); end
  endtask

  task automatic test_right_clamp();
    int want_seq [6] = '{44, 49, 54, 56, 56, 56};
    for (int i = 0; i < 6; i++) begin
      send_key(8'h23);
      commit_frame();
      m_x = want_seq[i];
      n_cmp++; if (pos_x !== 16'(m_x)) begin n_err++; $display("FAIL right_clamp[%0d]: got %0d want %0d", i, pos_x, m_x); end
    end
  endtask

  task automatic test_recentre();
    send_key(8'h2D);
    commit_frame();
    m_x = IX; m_y = IY;
    n_cmp++; if (pos_x !== 16'(IX)) begin n_err++; $display("FAIL recentre_x: got %0d want %0d", pos_x, IX); end
    n_cmp++; if (pos_y !== 16'(IY)) begin n_err++; $display("FAIL recentre_y: got %0d want %0d", pos_y, IY); end
  endtask

  task automatic test_left_clamp();
    int want_seq [9] = '{29, 24, 19, 14, 9, 4, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      send_key(8'h1C);
      commit_frame();
      m_x = want_seq[i];
      n_cmp++; if (pos_x !== 16'(m_x)) begin n_err++; $display("FAIL left_clamp[%0d]: got %0d want %0d", i, pos_x, m_x); end
    end
  endtask

  task automatic test_break_overwrite();
    send_key(8'hF0);
    n_cmp++; if (dbg_brk !== 1'b1) begin n_err++; $display("FAIL brk_set: got %b want 1", dbg_brk); end
    send_key(8'h23);
    n_cmp++; if (dbg_brk !== 1'b0) begin n_err++; $display("FAIL brk_clear: got %b want 0", dbg_brk); end
    commit_frame();
    n_cmp++; if (pos_x !== 16'(m_x)) begin n_err++; $display("FAIL brk_no_move: got %0d want %0d", pos_x, m_x); end
    send_key(8'h1D);
    send_key(8'h1B);
    commit_frame();
    m_y = 25;
    n_cmp++; if (pos_y !== 16'(m_y)) begin n_err++; $display("FAIL overwrite_y: got %0d want %0d", pos_y, m_y); end
  endtask

  // A key reaching the command register on the commit edge waits a frame.
  task automatic test_key_on_commit();
    send_key(8'h23);
    @(negedge clk);
    code = 8'h1C;
    strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vid.iVS = 1'b0;
    @(negedge clk);
    vid.iVS = 1'b1;
    strobe = 1'b0;
    m_x = 5;
    n_cmp++; if (pos_x !== 16'(m_x)) begin n_err++; $display("FAIL commit_uses_old: got %0d want %0d", pos_x, m_x); end
    repeat (2) @(negedge clk);
    commit_frame();
    m_x = 0;
    n_cmp++; if (pos_x !== 16'(m_x)) begin n_err++; $display("FAIL commit_new_next: got %0d want %0d", pos_x, m_x); end
  endtask

  task automatic test_visibility();
    send_key(8'h29);
    commit_frame();
    m_on = 1'b0;
    n_cmp++; if (sprite_on !== 1'b0) begin n_err++; $display("FAIL hide: got %b want 0", sprite_on); end
    test_frame();
    send_key(8'h1B);
    commit_frame();
    m_y = 30;
    n_cmp++; if (pos_y !== 16'(m_y)) begin n_err++; $display("FAIL hidden_down: got %0d want %0d", pos_y, m_y); end
    send_key(8'h2D);
    commit_frame();
    m_x = IX; m_y = IY;
    n_cmp++; if ({pos_x, pos_y} !== {16'(IX), 16'(IY)}) begin n_err++; $display("FAIL hidden_recentre: got %0d,%0d want %0d,%0d", pos_x, pos_y, IX, IY); end
    n_cmp++; if (sprite_on !== 1'b0) begin n_err++; $display("FAIL recentre_keeps_hidden: got %b want 0", sprite_on); end
  endtask

  task automatic test_async_reset();
    send_key(8'h23);
    commit_frame();
    send_key(8'h1B);
    @(negedge clk);
    vid.iBLANK_n = 1'b1; vid.bgr_in = BG;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({pos_x, pos_y} !== {16'(IX), 16'(IY)}) begin n_err++; $display("FAIL areset_pos: got %0d,%0d want %0d,%0d", pos_x, pos_y, IX, IY); end
    n_cmp++; if (sprite_on !== 1'b1) begin n_err++; $display("FAIL areset_on: got %b want 1", sprite_on); end
    n_cmp++;
    if ({vid.oBLANK_n, vid.oHS, vid.oVS, vid.bgr_out} !== {3'b011, 24'h0}) begin
      n_err++; $display("FAIL areset_video: got %h want %h", {vid.oBLANK_n, vid.oHS, vid.oVS, vid.bgr_out}, {3'b011, 24'h0});
    end
    @(negedge clk);
    vid.iBLANK_n = 1'b0;
    rst_n = 1'b1;
    m_x = IX; m_y = IY; m_on = 1'b1;
    commit_frame();
    n_cmp++; if (pos_y !== 16'(IY)) begin n_err++; $display("FAIL areset_cmd_cleared: got %0d want %0d", pos_y, IY); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_move_right();
    test_right_clamp();
    test_recentre();
    test_left_clamp();
    test_break_overwrite();
    test_key_on_commit();
    test_visibility();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
